cpu_di_arbiter: RTL and testbench
=================================

// Module: cpu_di_arbiter
// PURPOSE
//  Parametrised successor to the Z80 data-in select logic. Selects one of NCH device
//  DATA OUT buses onto the CPU DATA INPUT bus using fixed priority (channel 0 highest).
//  Inserts per-channel wait states and holds the result for the whole read cycle.
//  Sits between the address/port decoders and the CPU DI pins. The fabric has no
//  internal tri-states, so this is the only driver of the DI bus.
// PARAMETERS
//  NCH       8      number of source channels (1..16)
//  DW        8      data width per channel
//  WS_W      4      width of per-channel wait-state count
//  IDLE_DATA 8'h00  value returned when no channel is selected (NOP); DW bits wide
// PORTS
//  pll0_250MHz  in   1         system clock; all logic on its rising edge
//  reset        in   1         asynchronous reset, active-high
//  rd_strobe    in   1         CPU read cycle active (level), synchronous to clock
//  src_cs       in   NCH       per-channel select; bit i for channel i
//  src_data     in   NCH*DW    channel i data at [i*DW +: DW]
//  src_ws       in   NCH*WS_W  channel i wait states at [i*WS_W +: WS_W]
//  out_data     out  DW        registered data to CPU DI bus
//  out_valid    out  1         out_data is valid for the current read
//  cpu_wait     out  1         active-high wait request to the CPU wait logic
//  collision    out  1         sticky: more than one src_cs was high at read start
//  coll_count   out  8         saturating count of collision events
// BEHAVIOUR
//  Reset (async): state=IDLE, out_data=IDLE_DATA, out_valid=0, cpu_wait=0,
//   collision=0, coll_count=0.
//  start = rd_strobe & ~rd_strobe_q, where rd_strobe_q is rd_strobe registered.
//  At start: winner = lowest index i with src_cs[i]=1. winner and its src_ws value
//   are latched. Later src_cs changes in the same cycle are ignored.
//  FSM states:
//   IDLE  : on start with a winner and ws>0 -> WAIT; cnt=ws-1; cpu_wait=1 next clock.
//           on start with a winner and ws=0 -> DRIVE; out_data=src_data[winner]; out_valid=1.
//           on start with no src_cs -> DRIVE; out_data=IDLE_DATA; out_valid=1.
//   WAIT  : cpu_wait=1. cnt decrements each clock.
//           At cnt==0: out_data=src_data[winner] (sampled that clock), out_valid=1,
//           cpu_wait=0, go to DRIVE.
//   DRIVE : hold out_data and out_valid=1 while rd_strobe=1.
//           rd_strobe=0 -> IDLE with out_valid=0.
//  Latency: ws=0 gives out_valid 1 clock after start. ws=N gives N+1 clocks after start.
//   cpu_wait is high for exactly N clocks.
//  rd_strobe falls during WAIT: abort to IDLE, cpu_wait=0, out_valid=0, out_data unchanged.
//  out_data is never cleared outside reset; it holds the last value between reads.
//  rd_strobe held high across transactions gives no new start. A new read needs a
//   low clock on rd_strobe first.
//  Channels with index >= NCH do not exist; width slicing uses NCH exactly.
//  Collision: at start, popcount(src_cs)>1 sets collision=1 (sticky until reset).
//   coll_count increments and saturates at 8'hFF. The winner is still chosen by priority.
// CONFIGURATION
//  DIMUX_COLLISION_EN defined  : collision detection as above.
//  DIMUX_COLLISION_EN undefined: no popcount logic; collision=0 and coll_count=0 always.
//   Ports remain present.
// TESTING
//  1 Reset mid-WAIT (ch2 ws=5, reset after 2 clocks) -> all outputs at reset values
//    immediately (async), FSM in IDLE.
//  2 src_cs=0x01, ch0 data=8'hA5, ws=0, rd_strobe 1 for 4 clocks -> out_data=A5,
//    out_valid=1 from clock 1 until rd_strobe falls, cpu_wait never high.
//  3 src_cs=0x08, ch3 ws=3, data=8'h3C -> cpu_wait high 3 clocks, out_valid at clock 4,
//    out_data=3C.
//  4 src_cs=0x0A at start (ch1=8'h11, ch3=8'h33) -> out_data=11, collision=1,
//    coll_count=1. 300 such reads -> coll_count=FF.
//  5 No src_cs at start -> out_data=00, out_valid=1 next clock. src_cs asserted mid-cycle
//    -> no change.
//  6 ch5 ws=4, rd_strobe dropped after 2 clocks -> cpu_wait=0, out_valid stays 0,
//    out_data keeps its prior value. Next read proceeds normally.

Source files
------------

// File: rtl/cpu_di_arbiter_if.sv
// CPU data-in arbiter bus: read strobe, per-channel selects/data/waits in,
// registered DI data, valid, wait request and collision status out.
interface cpu_di_arbiter_if #(
  parameter int NCH  = 8,
  parameter int DW   = 8,
  parameter int WS_W = 4
);
  logic                rd_strobe;
  logic [NCH-1:0]      src_cs;
  logic [NCH*DW-1:0]   src_data;
  logic [NCH*WS_W-1:0] src_ws;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                cpu_wait;
  logic                collision;
  logic [7:0]          coll_count;

  modport master (
    output rd_strobe, src_cs, src_data, src_ws,
    input  out_data, out_valid, cpu_wait,
    input  collision, coll_count
  );

  modport slave (
    input  rd_strobe, src_cs, src_data, src_ws,
    output out_data, out_valid, cpu_wait,
    output collision, coll_count
  );
endinterface

// File: rtl/cpu_di_arbiter.sv
// Fixed-priority CPU DI mux (ch0 highest) with per-channel wait states.
// Ports: pll0_250MHz clock, reset (async, high), bus (slave modport).
// Optional: DIMUX_COLLISION_EN enables multi-select collision tracking.
module cpu_di_arbiter #(
  parameter int             NCH       = 8,
  parameter int             DW        = 8,
  parameter int             WS_W      = 4,
  parameter logic [DW-1:0]  IDLE_DATA = '0
) (
  input logic pll0_250MHz,
  input logic reset,
  cpu_di_arbiter_if.slave bus
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  logic [1:0]      state;
  logic            rd_q;
  logic            start;
  logic [WS_W-1:0] cnt;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_q;
  logic            hit;
  logic [WS_W-1:0] ws_sel;
  logic [DW-1:0]   sel_data;
  logic [DW-1:0]   done_data;
  logic [DW-1:0]   data_r;
  logic            valid_r;
  logic            wait_r;

  assign start = bus.rd_strobe & ~rd_q;

  // Lowest set select wins; scan downward so the last hit is the lowest.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.src_cs[i]) begin
        win = IW'(i);
        hit = 1'b1;
      end
    end
  end

  assign ws_sel    = bus.src_ws[int'(win)*WS_W +: WS_W];
  assign sel_data  = bus.src_data[int'(win)*DW +: DW];
  assign done_data = bus.src_data[int'(win_q)*DW +: DW];

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rd_q    <= 1'b0;
      cnt     <= '0;
      win_q   <= '0;
      data_r  <= IDLE_DATA;
      valid_r <= 1'b0;
      wait_r  <= 1'b0;
    end else begin
      rd_q <= bus.rd_strobe;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            win_q <= win;
            if (hit && ws_sel != '0) begin
              state  <= S_WAIT;
              cnt    <= ws_sel - WS_W'(1);
              wait_r <= 1'b1;
            end else begin
              state   <= S_DRIVE;
              data_r  <= hit ? sel_data : IDLE_DATA;
              valid_r <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          // An aborted read leaves the previous data on the bus.
          if (!bus.rd_strobe) begin
            state  <= S_IDLE;
            wait_r <= 1'b0;
          end else if (cnt == '0) begin
            state   <= S_DRIVE;
            data_r  <= done_data;
            valid_r <= 1'b1;
            wait_r  <= 1'b0;
          end else begin
            cnt <= cnt - WS_W'(1);
          end
        end
        S_DRIVE: begin
          if (!bus.rd_strobe) begin
            state   <= S_IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          valid_r <= 1'b0;
          wait_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data  = data_r;
  assign bus.out_valid = valid_r;
  assign bus.cpu_wait  = wait_r;

`ifdef DIMUX_COLLISION_EN
  logic       multi;
  logic       coll_r;
  logic [7:0] ccnt_r;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(bus.src_cs & (bus.src_cs - NCH'(1)));

  always_ff @(posedge pll0_250MHz or posedge reset) begin
    if (reset) begin
      coll_r <= 1'b0;
      ccnt_r <= 8'h00;
    end else if (start && multi) begin
      coll_r <= 1'b1;
      if (ccnt_r != 8'hFF) ccnt_r <= ccnt_r + 8'h01;
    end
  end

  assign bus.collision  = coll_r;
  assign bus.coll_count = ccnt_r;
`else
  assign bus.collision  = 1'b0;
  assign bus.coll_count = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_di_arbiter.sv
// Self-checking bench for cpu_di_arbiter: directed reads plus randomized
// reads checked cycle by cycle against a transaction-level model.
module tb_cpu_di_arbiter;

  localparam int NCH  = 8;
  localparam int DW   = 8;
  localparam int WS_W = 4;
  localparam logic [DW-1:0] IDLE = 8'h00;

  logic clk;
  logic rst;

  cpu_di_arbiter_if #(.NCH(NCH), .DW(DW), .WS_W(WS_W)) bus ();

  cpu_di_arbiter #(
    .NCH(NCH), .DW(DW), .WS_W(WS_W), .IDLE_DATA(IDLE)
  ) dut (
    .pll0_250MHz(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] cur;
  logic          coll_e;
  int            ccnt_e;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One read: rd_strobe high for len clocks, then low for gap clocks.
  // Selects and wait counts are scrambled after the start clock.
  task automatic do_read(input logic [NCH-1:0]      cs,
                         input logic [NCH*WS_W-1:0] wsv,
                         input logic [NCH*DW-1:0]   dv,
                         input int len, input int gap);
    int w;
    int n;
    logic [DW-1:0] nd;
    w = -1;
    for (int i = NCH - 1; i >= 0; i--) if (cs[i]) w = i;
    n  = (w < 0) ? 0 : int'(wsv[w*WS_W +: WS_W]);
    nd = (w < 0) ? IDLE : dv[w*DW +: DW];
`ifdef DIMUX_COLLISION_EN
    if ($countones(cs) > 1) begin
      coll_e = 1'b1;
      if (ccnt_e < 255) ccnt_e++;
    end
`endif
    bus.src_cs    = cs;
    bus.src_ws    = wsv;
    bus.src_data  = dv;
    bus.rd_strobe = 1'b1;
    for (int k = 0; k < len + gap; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == n && k < len) cur = nd;
      check("wait", 32'(bus.cpu_wait), 32'(k < len && k < n));
      check("valid", 32'(bus.out_valid), 32'(k < len && k >= n));
      check("data", 32'(bus.out_data), 32'(cur));
      bus.rd_strobe = (k + 1 < len);
      if (k == 0) begin
        bus.src_cs = NCH'($urandom);
        bus.src_ws = $urandom;
      end
    end
    check("coll", 32'(bus.collision), 32'(coll_e));
    check("ccnt", 32'(bus.coll_count), 32'(ccnt_e));
  endtask

  function automatic logic [NCH*WS_W-1:0] rand_ws();
    logic [NCH*WS_W-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      if ($urandom_range(0, 2) != 0)
        v[i*WS_W +: WS_W] = WS_W'($urandom_range(1, 6));
    return v;
  endfunction

  function automatic logic [NCH*DW-1:0] rand_data();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [NCH-1:0] rand_cs();
    int m;
    m = $urandom_range(0, 3);
    if (m == 0) return '0;
    if (m == 1) return NCH'(1) << $urandom_range(0, NCH - 1);
    return NCH'($urandom);
  endfunction

  initial begin
    logic [NCH*WS_W-1:0] wsv;
    logic [NCH*DW-1:0]   dv;

    rst = 1'b1;
    bus.rd_strobe = 1'b0;
    bus.src_cs    = '0;
    bus.src_ws    = '0;
    bus.src_data  = '0;
    cur    = IDLE;
    coll_e = 1'b0;
    ccnt_e = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);

    // ch0, no wait states
    dv = rand_data();
    dv[7:0] = 8'hA5;
    do_read(8'h01, '0, dv, 4, 2);

    // ch3, three wait states
    wsv = '0;
    wsv[3*WS_W +: WS_W] = 4'd3;
    dv[3*DW +: DW] = 8'h3C;
    do_read(8'h08, wsv, dv, 6, 2);

    // ch1 and ch3 together: ch1 wins
    dv[1*DW +: DW] = 8'h11;
    dv[3*DW +: DW] = 8'h33;
    do_read(8'h0A, '0, dv, 3, 1);

    // nothing selected
    do_read(8'h00, rand_ws(), rand_data(), 4, 1);

    // ch5 aborted mid-wait, then a normal read
    wsv = '0;
    wsv[5*WS_W +: WS_W] = 4'd4;
    dv[5*DW +: DW] = 8'h5E;
    do_read(8'h20, wsv, dv, 2, 2);
    do_read(8'h20, wsv, dv, 7, 2);

    // saturation of the collision counter
    for (int r = 0; r < 300; r++) begin
      dv = rand_data();
      do_read(8'h0A, '0, dv, 1, 1);
    end

    for (int r = 0; r < 250; r++)
      do_read(rand_cs(), rand_ws(), rand_data(),
              $urandom_range(1, 10), $urandom_range(1, 3));

    // reset asserted while ch2 is waiting
    wsv = '0;
    wsv[2*WS_W +: WS_W] = 4'd5;
    bus.src_cs = 8'h04;
    bus.src_ws = wsv;
    bus.rd_strobe = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_wait", 32'(bus.cpu_wait), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_wait", 32'(bus.cpu_wait), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_data", 32'(bus.out_data), 32'(IDLE));
    check("arst_coll", 32'(bus.collision), 32'd0);
    check("arst_ccnt", 32'(bus.coll_count), 32'd0);
    bus.rd_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cur    = IDLE;
    coll_e = 1'b0;
    ccnt_e = 0;
    @(negedge clk);
    dv = rand_data();
    dv[2*DW +: DW] = 8'h2D;
    do_read(8'h04, wsv, dv, 8, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
